// File: rtl/regfile_read_stage_pkg.sv
// regfile_read_stage_pkg: shared widths, zero-register index and operand select encodings
package regfile_read_stage_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam logic [DEF_ADDR_W-1:0] ZERO_REG = '0;
  localparam logic SEL_ZERO = 1'b0;
  localparam logic SEL_PASS = 1'b1;
endpackage

// File: rtl/regfile_read_stage_bank.sv
// regfile_bank: NREGS x DATA_W storage, async clear, one write port (index 0 dropped), two comb read ports
// ports: clk, reset; wr_en/wr_addr/wr_data write; ra_addr->ra_data, rb_addr->rb_data reads
module regfile_bank
  import regfile_read_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data
);
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];
  always_comb begin
    mem_d = mem_q;
    if (wr_en && wr_addr != ADDR_W'(ZERO_REG)) mem_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) mem_q <= '{default: '0};
    else mem_q <= mem_d;
  assign ra_data = mem_q[ra_addr];
  assign rb_data = mem_q[rb_addr];
endmodule

// File: rtl/regfile_read_stage.sv
// regfile_read_stage: two-read register file feeding a registered operand stage with bypass, stall and flush
// ports: clk, reset (async high); in_valid/rs_addr/rt_addr decode slot; stall, flush;
//        wr_en/wr_addr/wr_data writeback; rs_data/rt_data, rs_sel/rt_sel, out_valid registered outputs
module regfile_read_stage
  import regfile_read_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREGS  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_sel,
  output logic              rt_sel,
  output logic              out_valid
);
  logic [DATA_W-1:0] rs_rd, rt_rd, rs_data_d, rt_data_d, rs_data_q, rt_data_q;
  logic [ADDR_W-1:0] rs_idx_d, rt_idx_d, rs_idx_q, rt_idx_q;
  logic rs_sel_d, rt_sel_d, out_valid_d, rs_sel_q, rt_sel_q, out_valid_q;
  logic wr_live, rs_byp, rt_byp, rs_hit, rt_hit;
  regfile_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_bank (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ra_addr(rs_addr), .rb_addr(rt_addr), .ra_data(rs_rd), .rb_data(rt_rd)
  );
  // wr_live excludes index 0, so bypass and held-operand refresh can never deliver data for r0
  always_comb begin
    wr_live     = wr_en && wr_addr != ADDR_W'(ZERO_REG);
    rs_byp      = wr_live && wr_addr == rs_addr;
    rt_byp      = wr_live && wr_addr == rt_addr;
    rs_hit      = wr_live && wr_addr == rs_idx_q;
    rt_hit      = wr_live && wr_addr == rt_idx_q;
    rs_data_d   = flush ? '0 : stall ? (rs_hit ? wr_data : rs_data_q) : (rs_byp ? wr_data : rs_rd);
    rt_data_d   = flush ? '0 : stall ? (rt_hit ? wr_data : rt_data_q) : (rt_byp ? wr_data : rt_rd);
    rs_sel_d    = flush ? SEL_ZERO : stall ? rs_sel_q :
                  (in_valid && rs_addr != ADDR_W'(ZERO_REG)) ? SEL_PASS : SEL_ZERO;
    rt_sel_d    = flush ? SEL_ZERO : stall ? rt_sel_q :
                  (in_valid && rt_addr != ADDR_W'(ZERO_REG)) ? SEL_PASS : SEL_ZERO;
    out_valid_d = flush ? 1'b0 : stall ? out_valid_q : in_valid;
    rs_idx_d    = flush ? '0 : stall ? rs_idx_q : rs_addr;
    rt_idx_d    = flush ? '0 : stall ? rt_idx_q : rt_addr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      rs_sel_q    <= SEL_ZERO;
      rt_sel_q    <= SEL_ZERO;
      out_valid_q <= 1'b0;
      rs_idx_q    <= '0;
      rt_idx_q    <= '0;
    end else begin
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      rs_sel_q    <= rs_sel_d;
      rt_sel_q    <= rt_sel_d;
      out_valid_q <= out_valid_d;
      rs_idx_q    <= rs_idx_d;
      rt_idx_q    <= rt_idx_d;
    end
  assign rs_data   = rs_data_q;
  assign rt_data   = rt_data_q;
  assign rs_sel    = rs_sel_q;
  assign rt_sel    = rt_sel_q;
  assign out_valid = out_valid_q;
endmodule
